// File: rtl/if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, drives a sync-read imem, applies stalls and ID redirects.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       pc_ID,
    output logic [31:0]       pc_plus4_ID,
    output logic [31:0]       instr_ID,
    output logic              valid_ID
);

    typedef enum logic {
        S_FILL,
        S_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc4_id_q, pc4_id_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = jump | branch_taken;

    always_comb begin
        pc_d = pc_plus4;
        if (state_q == S_FILL || stall) begin
            pc_d = pc_q;
        end else if (jump) begin
            pc_d = jump_target & 32'hFFFF_FFFC;
        end else if (branch_taken) begin
            pc_d = branch_target & 32'hFFFF_FFFC;
        end
    end

    // imem registers this address, so its data lines up with pc_q next cycle
    assign imem_addr = rst ? pc_d[ADDR_W+1:2] : RESET_PC[ADDR_W+1:2];

    always_comb begin
        state_d  = S_RUN;
        pc_id_d  = pc_id_q;
        pc4_id_d = pc4_id_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (state_q == S_FILL || (!stall && redirect)) begin
            pc_id_d  = 32'd0;
            pc4_id_d = 32'd0;
            instr_d  = NOP;
            valid_d  = 1'b0;
        end else if (!stall) begin
            pc_id_d  = pc_q;
            pc4_id_d = pc_plus4;
            instr_d  = imem_rdata;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FILL;
            pc_q     <= RESET_PC;
            pc_id_q  <= 32'd0;
            pc4_id_q <= 32'd0;
            instr_q  <= NOP;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_id_q  <= pc_id_d;
            pc4_id_q <= pc4_id_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    assign pc_ID       = pc_id_q;
    assign pc_plus4_ID = pc4_id_q;
    assign instr_ID    = instr_q;
    assign valid_ID    = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed steps plus random
// stall/redirect traffic against a program-order fetch model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_ID;
    logic [31:0] pc_plus4_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;

    logic [31:0] mem [256];

    int compared = 0;
    int mism     = 0;

    // model: address being fetched, fill flag, expected ID contents
    logic        m_fill;
    logic [31:0] m_pc;
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        e_valid;
    logic [31:0] e_next;

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .pc_ID        (pc_ID),
        .pc_plus4_ID  (pc_plus4_ID),
        .instr_ID     (instr_ID),
        .valid_ID     (valid_ID)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fill  = 1'b1;
        m_pc    = 32'h0;
        e_pc    = 32'h0;
        e_pc4   = 32'h0;
        e_instr = 32'h0;
        e_valid = 1'b0;
    endtask

    task automatic bubble();
        e_pc    = 32'h0;
        e_pc4   = 32'h0;
        e_instr = 32'h0;
        e_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".pc"}, pc_ID, e_pc);
        chk({tag, ".pc4"}, pc_plus4_ID, e_pc4);
        chk({tag, ".instr"}, instr_ID, e_instr);
        chk({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, e_valid});
    endtask

    // called 1 time unit after a rising edge; ends at the same phase
    task automatic step(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input string tag);
        stall         = s;
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        if (m_fill || s) e_next = m_pc;
        else if (j)      e_next = {jt[31:2], 2'b00};
        else if (b)      e_next = {bt[31:2], 2'b00};
        else             e_next = m_pc + 32'd4;
        #1;
        chk({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, e_next[9:2]});
        if (m_fill) begin
            bubble();
            m_fill = 1'b0;
        end else if (!s) begin
            if (j || b) begin
                bubble();
            end else begin
                e_pc    = m_pc;
                e_pc4   = m_pc + 32'd4;
                e_instr = mem[m_pc[9:2]];
                e_valid = 1'b1;
            end
            m_pc = e_next;
        end
        @(posedge clk);
        #1;
        chk_out(tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        rst = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;
        model_reset();
        #1;
        chk_out("reset");
        chk("reset.addr", {24'd0, imem_addr}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        step(0, 0, 0, 0, 0, "fill");
        chk("fill.valid0", {31'd0, valid_ID}, 32'h0);
        step(0, 0, 0, 0, 0, "seq0");
        chk("seq0.instr", instr_ID, 32'h100);
        step(0, 0, 0, 0, 0, "seq1");
        chk("seq1.instr", instr_ID, 32'h101);
        chk("seq1.pc", pc_ID, 32'h4);
        step(1, 0, 0, 0, 0, "stall0");
        step(1, 0, 0, 0, 0, "stall1");
        chk("stall1.instr", instr_ID, 32'h101);
        chk("stall1.pc", pc_ID, 32'h4);
        step(0, 0, 0, 0, 0, "unstall");
        chk("unstall.instr", instr_ID, 32'h102);
        chk("unstall.pc", pc_ID, 32'h8);

        step(0, 1, 32'h40, 0, 0, "br");
        chk("br.instr", instr_ID, 32'h0);
        step(0, 0, 0, 0, 0, "br.tgt");
        chk("br.tgt.pc", pc_ID, 32'h40);
        chk("br.tgt.instr", instr_ID, 32'h110);

        step(0, 1, 32'h40, 1, 32'h80, "jb");
        step(0, 0, 0, 0, 0, "jb.tgt");
        chk("jb.tgt.pc", pc_ID, 32'h80);

        step(1, 1, 32'h40, 0, 0, "stbr");
        chk("stbr.pc", pc_ID, 32'h80);
        step(0, 1, 32'h40, 0, 0, "stbr.rel");
        chk("stbr.rel.valid", {31'd0, valid_ID}, 32'h0);
        step(0, 0, 0, 0, 0, "stbr.tgt");
        chk("stbr.tgt.pc", pc_ID, 32'h40);

        step(0, 0, 0, 1, 32'h23, "mis");
        step(0, 0, 0, 0, 0, "mis.tgt");
        chk("mis.tgt.pc", pc_ID, 32'h20);
        chk("mis.tgt.instr", instr_ID, 32'h108);

        step(0, 0, 0, 1, 32'hFFFF_FFFC, "wrap");
        step(0, 0, 0, 0, 0, "wrap0");
        chk("wrap0.pc4", pc_plus4_ID, 32'h0);
        step(0, 0, 0, 0, 0, "wrap1");
        chk("wrap1.pc", pc_ID, 32'h0);

        for (int n = 0; n < 300; n++) begin
            step($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom,
                 $urandom_range(7) == 0, $urandom, "rnd");
        end

        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_out("midrst");
        chk("midrst.addr", {24'd0, imem_addr}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, "rfill");
        step(0, 0, 0, 0, 0, "rseq0");
        chk("rseq0.instr", instr_ID, 32'h100);
        chk("rseq0.pc", pc_ID, 32'h0);

        for (int n = 0; n < 200; n++) begin
            step($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom,
                 $urandom_range(6) == 0, $urandom, "rnd2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end

endmodule
